// File: rtl/fetch_aligner_pkg.sv
// Shared fetch/decode definitions: reset PC default, halfword queue depth
// and the compact-instruction detect rule, also used by the decoder.
package fetch_aligner_pkg;

    localparam logic [31:0] FA_RESET_PC = 32'h0000_0000;
    localparam int          HWQ_DEPTH   = 3;

    typedef logic [15:0] halfword_t;

    // A halfword starts a compact (16-bit) instruction unless its low two bits are 2'b11.
    function automatic logic is_compact(input halfword_t hw);
        return hw[1:0] != 2'b11;
    endfunction

    // Instruction length in halfwords for the given head halfword.
    function automatic logic [1:0] hw_len(input halfword_t hw);
        return is_compact(hw) ? 2'd1 : 2'd2;
    endfunction

endpackage

// File: rtl/fetch_aligner_if.sv
// Instruction memory bus between the fetch aligner (master) and memory (slave).
// A transfer is any cycle with mem_req && mem_ready; mem_rdata is sampled then.
interface fetch_aligner_if;

    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (output mem_req, output mem_addr, input mem_ready, input mem_rdata);
    modport slave  (input mem_req, input mem_addr, output mem_ready, output mem_rdata);

endinterface

// File: rtl/fetch_aligner_hw_queue.sv
// Three-entry halfword queue: pops 0..2 from the head and pushes 0..2 at the
// tail in the same cycle; pops are applied before pushes.
module hw_queue
    import fetch_aligner_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      flush_i,
    input  logic [1:0] pop_i,
    input  logic [1:0] push_i,
    input  halfword_t push_lo_i,
    input  halfword_t push_hi_i,
    output halfword_t head_o,
    output halfword_t second_o,
    output logic [1:0] count_o
);

    halfword_t  entry_q [HWQ_DEPTH];
    halfword_t  entry_d [HWQ_DEPTH];
    halfword_t  rem     [HWQ_DEPTH];
    logic [1:0] count_q;
    logic [1:0] count_d;
    logic [1:0] rem_count;

    // Shift out popped halfwords, then place pushed halfwords behind the survivors.
    always_comb begin
        // NOTE: every variable gets a default at the top so no path leaves it unassigned (no latch).
        rem = entry_q;
        case (pop_i)
            2'd1: begin
                rem[0] = entry_q[1];
                rem[1] = entry_q[2];
            end
            2'd2:    rem[0] = entry_q[2];
            default: ;
        endcase
        rem_count = count_q - pop_i;
        entry_d   = rem;
        for (int i = 0; i < HWQ_DEPTH; i++) begin
            if (push_i != 2'd0 && 2'(i) == rem_count)         entry_d[i] = push_lo_i;
            if (push_i == 2'd2 && 2'(i) == rem_count + 2'd1)  entry_d[i] = push_hi_i;
        end
        count_d = flush_i ? 2'd0 : rem_count + push_i;
    end

    // Queue storage and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 2'd0;
            // NOTE: storage is reset too, so the head reads zero and the instruction output is zero in reset.
            entry_q <= '{default: '0};
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            count_q <= count_d;
            entry_q <= entry_d;
        end
    end

    assign head_o   = entry_q[0];
    assign second_o = entry_q[1];
    assign count_o  = count_q;

endmodule

// File: rtl/fetch_aligner.sv
// Fetch aligner: fetches 32-bit words, splits them into halfwords and
// presents aligned 16/32-bit instructions to the decoder.
module fetch_aligner
    import fetch_aligner_pkg::*;
#(
    parameter logic [31:0] RESET_PC = FA_RESET_PC
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_pc,
    input  logic                   stall,
    fetch_aligner_if.master        mem_bus,
    output logic                   instr_valid,
    output logic [31:0]            instruction,
    output logic [31:0]            instr_pc
);

    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] fetch_addr_q, fetch_addr_d;
    logic        skip_low_q, skip_low_d;

    halfword_t   head, second;
    logic [1:0]  hw_count, head_len, pop, push;
    logic        consume, transfer;

    hw_queue u_hw_queue (
        .clk       (clk),
        .rst       (reset),
        .flush_i   (redirect_valid),
        .pop_i     (pop),
        .push_i    (push),
        .push_lo_i (skip_low_q ? mem_bus.mem_rdata[31:16] : mem_bus.mem_rdata[15:0]),
        .push_hi_i (mem_bus.mem_rdata[31:16]),
        .head_o    (head),
        .second_o  (second),
        .count_o   (hw_count)
    );

    // Decoder-side outputs, consume decision and memory request, all from current queue state.
    always_comb begin
        head_len         = hw_len(head);
        instr_valid      = !reset && !redirect_valid && (hw_count >= head_len);
        consume          = instr_valid && !stall;
        pop              = consume ? head_len : 2'd0;
        // Request when at most one halfword survives this cycle, leaving room for a whole word.
        mem_bus.mem_req  = !reset && ((hw_count - pop) <= 2'd1);
        mem_bus.mem_addr = fetch_addr_q;
        transfer         = mem_bus.mem_req && mem_bus.mem_ready;
        // Redirect discards any same-cycle transfer data.
        push             = (transfer && !redirect_valid) ? (skip_low_q ? 2'd1 : 2'd2) : 2'd0;
        instruction      = is_compact(head) ? {16'h0000, head} : {second, head};
        instr_pc         = buf_pc_q;
    end

    // Next head PC, fetch address and skip flag; redirect wins over consume and transfer.
    always_comb begin
        buf_pc_d     = buf_pc_q;
        fetch_addr_d = fetch_addr_q;
        skip_low_d   = skip_low_q;
        if (redirect_valid) begin
            buf_pc_d     = redirect_pc & ~32'd1;
            fetch_addr_d = redirect_pc & ~32'd3;
            skip_low_d   = redirect_pc[1];
        end else begin
            if (consume)  buf_pc_d = buf_pc_q + {29'd0, pop, 1'b0};
            if (transfer) begin
                fetch_addr_d = fetch_addr_q + 32'd4;
                skip_low_d   = 1'b0;
            end
        end
    end

    // PC and fetch-address registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_pc_q     <= RESET_PC & ~32'd1;
            fetch_addr_q <= RESET_PC & ~32'd3;
            skip_low_q   <= RESET_PC[1];
        end else begin
            buf_pc_q     <= buf_pc_d;
            fetch_addr_q <= fetch_addr_d;
            skip_low_q   <= skip_low_d;
        end
    end

endmodule

// File: tb/tb_fetch_aligner.sv
// Bench for fetch_aligner: memory with configurable wait states, a
// stream model of the expected instruction sequence, and directed scenarios.
module tb_fetch_aligner;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        instr_valid;
    logic [31:0] instruction;
    logic [31:0] instr_pc;

    fetch_aligner_if mem_bus ();

    fetch_aligner #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .mem_bus        (mem_bus),
        .instr_valid    (instr_valid),
        .instruction    (instruction),
        .instr_pc       (instr_pc)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [128];
    int          wait_states;
    int          wait_cnt;
    int          n_checks;
    int          n_pass;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
    endtask

    // ---------------- stream model: what the decoder must see, from memory contents alone
    function automatic logic [15:0] hw_at(input logic [31:0] pc);
        logic [31:0] w;
        w = mem[pc[8:2]];
        return pc[1] ? w[31:16] : w[15:0];
    endfunction

    function automatic logic [31:0] model_instr(input logic [31:0] pc);
        logic [15:0] h;
        h = hw_at(pc);
        if (h[1:0] != 2'b11) return {16'h0000, h};
        return {hw_at(pc + 32'd2), h};
    endfunction

    function automatic logic [31:0] model_len(input logic [31:0] pc);
        logic [15:0] h;
        h = hw_at(pc);
        return (h[1:0] != 2'b11) ? 32'd2 : 32'd4;
    endfunction

    // ---------------- memory: ready after wait_states cycles of request, data from mem_addr
    initial begin
        wait_cnt          = 0;
        mem_bus.mem_ready = 1'b0;
        mem_bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            if (reset || redirect_valid || (mem_bus.mem_req && mem_bus.mem_ready)) wait_cnt = 0;
            else if (mem_bus.mem_req) wait_cnt++;
            #1;
            mem_bus.mem_ready = (wait_cnt >= wait_states);
            mem_bus.mem_rdata = mem[mem_bus.mem_addr[8:2]];
        end
    end

    // ---------------- compare process, sampled on the falling edge
    logic [31:0] exp_pc, held_ins, held_pc, prev_addr;
    logic        prev_hold, prev_wait;

    initial begin
        exp_pc    = RESET_PC & ~32'd1;
        prev_hold = 1'b0;
        prev_wait = 1'b0;
        held_ins  = '0;
        held_pc   = '0;
        prev_addr = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                check("rst_valid", instr_valid, 0);
                check("rst_req", mem_bus.mem_req, 0);
                check("rst_instr", instruction, 0);
                check("rst_pc", instr_pc, RESET_PC & ~32'd1);
                exp_pc    = RESET_PC & ~32'd1;
                prev_hold = 1'b0;
                prev_wait = 1'b0;
            end else begin
                if (prev_hold) begin
                    check("stall_valid", instr_valid, 1);
                    check("stall_instr", instruction, held_ins);
                    check("stall_pc", instr_pc, held_pc);
                end
                if (prev_wait) begin
                    check("req_hold", mem_bus.mem_req, 1);
                    check("addr_hold", mem_bus.mem_addr, prev_addr);
                end
                if (mem_bus.mem_req) check("addr_align", {30'd0, mem_bus.mem_addr[1:0]}, 0);
                if (redirect_valid) begin
                    check("redir_valid", instr_valid, 0);
                    exp_pc    = redirect_pc & ~32'd1;
                    prev_hold = 1'b0;
                    prev_wait = 1'b0;
                end else begin
                    if (instr_valid) begin
                        check("stream_instr", instruction, model_instr(exp_pc));
                        check("stream_pc", instr_pc, exp_pc);
                        if (!stall) exp_pc = exp_pc + model_len(exp_pc);
                    end
                    prev_hold = instr_valid && stall;
                    held_ins  = instruction;
                    held_pc   = instr_pc;
                    prev_wait = mem_bus.mem_req && !mem_bus.mem_ready;
                    prev_addr = mem_bus.mem_addr;
                end
            end
        end
    end

    // ---------------- stimulus helpers
    task automatic start_scenario();
        @(posedge clk);
        #1;
        reset          = 1'b1;
        redirect_valid = 1'b0;
        stall          = 1'b0;
        wait_states    = 0;
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic next_out(input string name, output logic [31:0] ins, output logic [31:0] pc,
                            output int waited);
        waited = 0;
        ins    = 'x;
        pc     = 'x;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (instr_valid) begin
                ins = instruction;
                pc  = instr_pc;
                return;
            end
            waited++;
        end
        n_checks++;
        $display("FAIL %s: no instr_valid within 40 cycles", name);
    endtask

    logic [31:0] ins, pc;
    int          w;

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed scenarios
    initial begin
        n_checks       = 0;
        n_pass         = 0;
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        stall          = 1'b0;
        wait_states    = 0;
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;

        // First fetch latency, then one full instruction per cycle.
        mem[0] = 32'h0050_0093;
        for (int i = 1; i < 16; i++) mem[i] = 32'h0000_0093 | (i << 20);
        check("pin_first", model_instr(0), 32'h0050_0093);
        do_reset();
        @(negedge clk);
        check("first_req", mem_bus.mem_req, 1);
        check("first_addr", mem_bus.mem_addr, 32'h0);
        check("first_not_valid", instr_valid, 0);
        @(negedge clk);
        check("first_valid", instr_valid, 1);
        check("first_instr", instruction, 32'h0050_0093);
        check("first_pc", instr_pc, 32'h0);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            check("thru_valid", instr_valid, 1);
            check("thru_pc", instr_pc, 32'(4 * i));
        end

        // Two compact instructions in one word.
        start_scenario();
        mem[0] = 32'h0001_4501;
        check("pin_c0", model_instr(0), 32'h0000_4501);
        check("pin_c1", model_instr(2), 32'h0000_0001);
        do_reset();
        next_out("cc_a", ins, pc, w);
        check("cc_a_instr", ins, 32'h0000_4501);
        check("cc_a_pc", pc, 32'h0);
        next_out("cc_b", ins, pc, w);
        check("cc_b_instr", ins, 32'h0000_0001);
        check("cc_b_pc", pc, 32'h2);
        check("cc_b_gap", w, 0);

        // Full instruction straddling a word boundary.
        start_scenario();
        mem[0] = 32'h0093_4505;
        mem[1] = 32'h4501_0050;
        check("pin_straddle", model_instr(2), 32'h0050_0093);
        do_reset();
        next_out("st_a", ins, pc, w);
        check("st_a_instr", ins, 32'h0000_4505);
        check("st_a_pc", pc, 32'h0);
        next_out("st_b", ins, pc, w);
        check("st_b_instr", ins, 32'h0050_0093);
        check("st_b_pc", pc, 32'h2);
        next_out("st_c", ins, pc, w);
        check("st_c_instr", ins, 32'h0000_4501);
        check("st_c_pc", pc, 32'h6);

        // Reset pulsed with three halfwords queued (same memory as above).
        do_reset();
        repeat (3) @(negedge clk);
        check("rp_pre", instruction, 32'h0050_0093);
        #1;
        reset = 1'b1;
        #1;
        check("rp_valid", instr_valid, 0);
        check("rp_req", mem_bus.mem_req, 0);
        check("rp_instr", instruction, 32'h0);
        check("rp_pc", instr_pc, RESET_PC);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rp_refetch_req", mem_bus.mem_req, 1);
        check("rp_refetch_addr", mem_bus.mem_addr, RESET_PC);
        next_out("rp_out", ins, pc, w);
        check("rp_out_instr", ins, 32'h0000_4505);
        check("rp_out_pc", pc, 32'h0);

        // Redirect to a halfword-aligned PC during a 3-wait-state request.
        start_scenario();
        mem[0]  = 32'h0093_4505;
        mem[64] = 32'h4505_AAAA;
        check("pin_redir", model_instr(32'h102), 32'h0000_4505);
        wait_states = 3;
        do_reset();
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        check("rd_addr", mem_bus.mem_addr, 32'h100);
        check("rd_req", mem_bus.mem_req, 1);
        next_out("rd_out", ins, pc, w);
        check("rd_out_instr", ins, 32'h0000_4505);
        check("rd_out_pc", pc, 32'h102);

        // Redirect in the same cycle as a zero-wait transfer: its data is dropped.
        start_scenario();
        mem[0]  = 32'h0093_4505;
        mem[64] = 32'h4505_AAAA;
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        next_out("rz_a", ins, pc, w);
        check("rz_a_instr", ins, 32'h0000_AAAA);
        check("rz_a_pc", pc, 32'h100);
        next_out("rz_b", ins, pc, w);
        check("rz_b_instr", ins, 32'h0000_4505);
        check("rz_b_pc", pc, 32'h102);

        // Stall held for three cycles with a valid instruction.
        start_scenario();
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h0060_0113;
        mem[2] = 32'h0070_0193;
        stall  = 1'b1;
        do_reset();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("sh_valid", instr_valid, 1);
            check("sh_instr", instruction, 32'h0050_0093);
            check("sh_pc", instr_pc, 32'h0);
            check("sh_req", mem_bus.mem_req, 0);
        end
        @(posedge clk);
        #1;
        stall = 1'b0;
        next_out("sh_rel", ins, pc, w);
        check("sh_rel_instr", ins, 32'h0050_0093);
        check("sh_rel_gap", w, 0);
        next_out("sh_next", ins, pc, w);
        check("sh_next_instr", ins, 32'h0060_0113);
        check("sh_next_pc", pc, 32'h4);
        check("sh_next_gap", w, 0);
        next_out("sh_third", ins, pc, w);
        check("sh_third_instr", ins, 32'h0070_0193);
        check("sh_third_pc", pc, 32'h8);

        @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_aligner.md
FETCH_ALIGNER -- requirements
Module: fetch_aligner

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, first fetch PC after reset (bit 0 ignored).
REQ-002 SHALL have ports: clk  in  1  rising-edge clock.
REQ-003 SHALL have ports: reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: redirect_valid  in  1  taken branch/jump; redirect_pc  in  32  new PC, bit 0 ignored.
REQ-005 SHALL have ports: stall  in  1  downstream not accepting this cycle.
REQ-006 SHALL have ports: mem_req  out  1; mem_addr  out  32  word-aligned; mem_ready  in  1; mem_rdata  in  32.
REQ-007 SHALL have ports: instr_valid  out  1; instruction  out  32  to decoder; instr_pc  out  32.

Function
REQ-008 SHALL hold a 3-entry halfword queue with count hw_count (0..3), head PC buf_pc, next fetch word address fetch_addr, and flag skip_low.
REQ-009 SHALL classify the head halfword as compact when bits[1:0] != 2'b11 (length 1), else full (length 2).
REQ-010 SHALL drive instr_valid = 1 when hw_count >= head length and redirect_valid = 0; otherwise 0.
REQ-011 SHALL drive instruction = {16'h0000, head} for compact, {second, head} for full; instr_pc = buf_pc; all combinational from queue state.
REQ-012 SHALL consume an instruction only in a cycle with instr_valid && !stall; on consume, pop length halfwords and set buf_pc += 2*length, modulo 2^32.
REQ-013 SHALL hold instruction and instr_pc stable while instr_valid && stall; SHALL never present the same instruction twice.
REQ-014 SHALL drive mem_req = 1 when (hw_count - consumed_this_cycle) <= 1 and reset = 0.
REQ-015 SHALL drive mem_addr = fetch_addr.
REQ-016 SHALL treat a transfer as the cycle with mem_req && mem_ready and sample mem_rdata in that cycle, with 0..N wait states.
REQ-017 SHALL allow only one outstanding request, with mem_addr stable until transfer except on redirect.
REQ-018 SHALL, on transfer, append rdata[15:0] then rdata[31:16], or only rdata[31:16] when skip_low = 1.
REQ-019 SHALL, on transfer, clear skip_low and set fetch_addr += 4, wrapping 32'hFFFF_FFFC -> 0.
REQ-020 SHALL apply consume and append in the same cycle: hw_count_next = hw_count - popped + appended, never exceeding 3.
REQ-021 SHALL, for a full instruction with only one halfword queued (straddling a word boundary), hold instr_valid = 0 until the next word arrives.
REQ-022 SHALL give redirect_valid priority over consume and transfer. Next state: hw_count = 0; buf_pc = redirect_pc & ~1; fetch_addr = redirect_pc & ~3; skip_low = redirect_pc[1]. Any same-cycle transfer data is discarded.
REQ-023 SHALL treat a halfword 16'h0000 as compact and output instruction = 32'h0000_0000, with no special handling.
REQ-024 SHALL, with zero-wait memory and no stall, sustain one aligned 32-bit instruction per cycle after the first fill, with 1-cycle latency from transfer to instr_valid.

Reset
REQ-025 SHALL, while reset = 1, hold: hw_count = 0; buf_pc = RESET_PC & ~1; fetch_addr = RESET_PC & ~3; skip_low = RESET_PC[1]; instr_valid = 0; mem_req = 0; instruction = 0; instr_pc = buf_pc.
REQ-026 SHALL take effect asynchronously, mid-transfer included, and discard all queued data; the first request SHALL issue in the first cycle after release.

Structure
REQ-027 SHALL place RESET_PC default, halfword-queue depth (3) and the compact-detect rule in the shared defines header used by the decoder.
REQ-028 SHALL place the queue in one sub-module hw_queue (3 x 16-bit entries, pop 0/1/2, push 0/1/2, count output); all other logic stays in fetch_aligner.

Verification
REQ-029 SHALL cover scenario: RESET_PC=0, zero-wait memory with word[0]=32'h0050_0093 -> cycle 1 after release: mem_req=1, mem_addr=0; cycle 2: instr_valid=1, instruction=32'h0050_0093, instr_pc=0.
REQ-030 SHALL cover scenario: word[0]=32'h0001_4501 -> consecutive outputs 32'h0000_4501 @pc 0, then 32'h0000_0001 @pc 2.
REQ-031 SHALL cover scenario: word[0]=32'h0093_4505, word[1]=32'h4501_0050 -> outputs 32'h0000_4505 @0, 32'h0050_0093 @2 (straddle), 32'h0000_4501 @6.
REQ-032 SHALL cover scenario: redirect_pc=32'h0000_0102 during a 3-wait-state request -> mem_addr=32'h100 next cycle, stale data discarded, first instr_pc=32'h102 taken from rdata[31:16].
REQ-033 SHALL cover scenario: stall held 3 cycles with instr_valid=1 -> instruction/instr_pc unchanged, mem_req=0 once hw_count>=2, exactly one output after release.
REQ-034 SHALL cover scenario: reset pulsed mid-stream at hw_count=3 -> instr_valid and mem_req 0 immediately, refetch from RESET_PC after release.
